// File: rtl/counter_pkg.sv
// Shared definitions for the prescaled timebase counter: mode encodings and
// the prescaler width rule.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    // Width of a counter that must hold 0..div; never narrower than one bit.
    function automatic int pre_width(input int unsigned div);
        int w;
        w = $clog2(div + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clken_gen.sv
// Clock-enable generator: emits a registered one-cycle strobe every
// DIV_RATIO+1 cycles; a synchronous clear restarts the period from zero.
module clken_gen
    import counter_pkg::*;
#(
    parameter int unsigned DIV_RATIO = 999999
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int PW = pre_width(DIV_RATIO);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV_RATIO);

    logic [PW-1:0] pre;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pre  <= '0;
            tick <= 1'b0;
        end else if (pre == PRE_MAX) begin
            pre  <= '0;
            tick <= 1'b1;
        end else begin
            pre  <= pre + PW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/prescaled_counter.sv
// General timebase/event counter: built-in prescaler plus a WIDTH-bit up/down
// counter with programmable limit, load, and wrap/saturate/one-shot modes.
module prescaled_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int unsigned DIV_RATIO = 999999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    mode_e            mode_q;
    logic             at_term;
    logic             step;
    logic             set_done;
    logic [WIDTH-1:0] next_count;

    // Holding the prescaler in clear also keeps tick low while frozen.
    clken_gen #(
        .DIV_RATIO (DIV_RATIO)
    ) prescaler_inst (
        .clk   (clk),
        .rst   (rst),
        .clear (load | ~run | done),
        .tick  (tick)
    );

    assign mode_q = mode_e'(mode);

    // With DIV_RATIO=0 tick can still be high right after done sets, so the
    // step itself is also gated by done.
    assign step    = tick & ~done;
    assign at_term = dir ? (count == '0) : (count >= limit);

    // NOTE: every signal driven here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        next_count = count;
        set_done   = 1'b0;
        if (at_term) begin
            case (mode_q)
                MODE_SAT: begin
                    next_count = dir ? '0 : limit;
                end
                MODE_ONESHOT: begin
                    next_count = dir ? '0 : limit;
                    set_done   = 1'b1;
                end
                default: begin
                    next_count = dir ? limit : '0;
                end
            endcase
        end else begin
            next_count = dir ? (count - ONE) : (count + ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (load) begin
            count <= load_value;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            tc <= step & at_term;
            if (step) begin
                count <= next_count;
            end
            if (mode_q != MODE_ONESHOT) begin
                done <= 1'b0;
            end else if (step && set_done) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed bench for prescaled_counter at WIDTH=4, DIV_RATIO=3 (strobe every
// fourth cycle); each vector drives one clock and checks all outputs after it.
module tb_prescaled_counter;
    import counter_pkg::*;

    localparam int WIDTH = 4;
    localparam int DIV   = 3;

    typedef struct {
        logic       rst;
        logic       run;
        logic       dir;
        logic [1:0] mode;
        logic [3:0] limit;
        logic       load;
        logic [3:0] load_value;
        logic [3:0] exp_count;
        logic       exp_tick;
        logic       exp_tc;
        logic       exp_done;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst, run, dir, load;
    logic [1:0]       mode;
    logic [WIDTH-1:0] limit, load_value;
    logic [WIDTH-1:0] count;
    logic             tick, tc, done;

    int passed = 0;
    int total  = 0;

    prescaled_counter #(
        .WIDTH     (WIDTH),
        .DIV_RATIO (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .dir        (dir),
        .mode       (mode),
        .limit      (limit),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .tick       (tick),
        .tc         (tc),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic rn, input logic d,
                                input logic [1:0] m, input logic [3:0] lim,
                                input logic ld, input logic [3:0] lv,
                                input logic [3:0] ec, input logic et,
                                input logic etc, input logic ed);
        vec_t v;
        v.rst = r; v.run = rn; v.dir = d; v.mode = m; v.limit = lim;
        v.load = ld; v.load_value = lv;
        v.exp_count = ec; v.exp_tick = et; v.exp_tc = etc; v.exp_done = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got count=%0d tick=%b tc=%b done=%b, want count=%0d tick=%b tc=%b done=%b",
                     name, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
        else
            passed++;
    endtask

    // Drive one vector, clock once, sample 1 ns after the edge.
    task automatic apply(input string name, input vec_t v);
        rst = v.rst; run = v.run; dir = v.dir; mode = v.mode; limit = v.limit;
        load = v.load; load_value = v.load_value;
        @(posedge clk);
        #1;
        check(name, {count, tick, tc, done},
              {v.exp_count, v.exp_tick, v.exp_tc, v.exp_done});
    endtask

    vec_t reset_tbl [8];

    initial begin
        int s;

        // Reset held 3 cycles with load and run asserted, then the first
        // strobe DIV+1 cycles after the last reset edge.
        reset_tbl[0] = mk(1, 1, 0, MODE_WRAP, 9, 1, 5, 0, 0, 0, 0);
        reset_tbl[1] = mk(1, 1, 0, MODE_WRAP, 9, 1, 5, 0, 0, 0, 0);
        reset_tbl[2] = mk(1, 1, 0, MODE_WRAP, 9, 1, 5, 0, 0, 0, 0);
        reset_tbl[3] = mk(0, 1, 0, MODE_WRAP, 9, 0, 5, 0, 0, 0, 0);
        reset_tbl[4] = mk(0, 1, 0, MODE_WRAP, 9, 0, 5, 0, 0, 0, 0);
        reset_tbl[5] = mk(0, 1, 0, MODE_WRAP, 9, 0, 5, 0, 0, 0, 0);
        reset_tbl[6] = mk(0, 1, 0, MODE_WRAP, 9, 0, 5, 0, 1, 0, 0);
        reset_tbl[7] = mk(0, 1, 0, MODE_WRAP, 9, 0, 5, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) apply($sformatf("reset[%0d]", i), reset_tbl[i]);

        // Up/WRAP to limit 9: a step on each e%4==1, tc only on 9 -> 0.
        apply("wrap_load", mk(0, 1, 0, MODE_WRAP, 9, 1, 0, 0, 0, 0, 0));
        for (int e = 1; e <= 44; e++) begin
            s = (e - 1) / 4;
            apply($sformatf("wrap e=%0d", e),
                  mk(0, 1, 0, MODE_WRAP, 9, 0, 0, 4'(s % 10), (e % 4) == 0,
                     (e % 4 == 1) && (s == 10), 0));
        end

        // Down/SAT from 2: 2,1,0,0,0 with tc on every strobe taken at 0.
        apply("sat_load", mk(0, 1, 1, MODE_SAT, 9, 1, 2, 2, 0, 0, 0));
        for (int e = 1; e <= 20; e++) begin
            s = (e - 1) / 4;
            apply($sformatf("sat e=%0d", e),
                  mk(0, 1, 1, MODE_SAT, 9, 0, 0, 4'((s >= 2) ? 0 : 2 - s), (e % 4) == 0,
                     (e % 4 == 1) && (s >= 3), 0));
        end

        // Up/ONESHOT to 5: sixth strobe gives tc+done, then everything freezes.
        apply("os_load", mk(0, 1, 0, MODE_ONESHOT, 5, 1, 0, 0, 0, 0, 0));
        for (int e = 1; e <= 36; e++) begin
            s = (e - 1) / 4;
            apply($sformatf("oneshot e=%0d", e),
                  mk(0, 1, 0, MODE_ONESHOT, 5, 0, 0, 4'((s > 5) ? 5 : s),
                     (e % 4 == 0) && (e <= 24), e == 25, e >= 25));
        end
        apply("os_mode_exit", mk(0, 1, 0, MODE_WRAP, 5, 0, 0, 5, 0, 0, 0));
        apply("os_reload", mk(0, 1, 0, MODE_ONESHOT, 5, 1, 3, 3, 0, 0, 0));
        for (int e = 1; e <= 9; e++) begin
            s = (e - 1) / 4;
            apply($sformatf("os_restart e=%0d", e),
                  mk(0, 1, 0, MODE_ONESHOT, 5, 0, 0, 4'(3 + s), (e % 4) == 0, 0, 0));
        end

        // Load coinciding with a strobe at count 7 wins; value above limit wraps.
        apply("ldtick_load0", mk(0, 1, 0, MODE_WRAP, 9, 1, 0, 0, 0, 0, 0));
        for (int e = 1; e <= 32; e++) begin
            s = (e - 1) / 4;
            apply($sformatf("ldtick e=%0d", e),
                  mk(0, 1, 0, MODE_WRAP, 9, 0, 0, 4'(s), (e % 4) == 0, 0, 0));
        end
        apply("ldtick_load12", mk(0, 1, 0, MODE_WRAP, 9, 1, 12, 12, 0, 0, 0));
        for (int e = 1; e <= 5; e++)
            apply($sformatf("ldtick_after e=%0d", e),
                  mk(0, 1, 0, MODE_WRAP, 9, 0, 0, (e == 5) ? 4'd0 : 4'd12,
                     e == 4, e == 5, 0));

        // Dropping run while tick is high still takes that step.
        apply("run_load0", mk(0, 1, 0, MODE_WRAP, 9, 1, 0, 0, 0, 0, 0));
        for (int e = 1; e <= 4; e++)
            apply($sformatf("run e=%0d", e), mk(0, 1, 0, MODE_WRAP, 9, 0, 0, 0, e == 4, 0, 0));
        for (int e = 1; e <= 4; e++)
            apply($sformatf("run_off e=%0d", e), mk(0, 0, 0, MODE_WRAP, 9, 0, 0, 1, 0, 0, 0));
        for (int e = 1; e <= 5; e++)
            apply($sformatf("run_on e=%0d", e),
                  mk(0, 1, 0, MODE_WRAP, 9, 0, 0, (e == 5) ? 4'd2 : 4'd1, e == 4, 0, 0));

        // Reset mid-count at 6 with the prescaler mid-period.
        apply("rst_load0", mk(0, 1, 0, MODE_WRAP, 9, 1, 0, 0, 0, 0, 0));
        for (int e = 1; e <= 26; e++) begin
            s = (e - 1) / 4;
            apply($sformatf("rst_pre e=%0d", e),
                  mk(0, 1, 0, MODE_WRAP, 9, 0, 0, 4'(s), (e % 4) == 0, 0, 0));
        end
        apply("rst_mid", mk(1, 1, 0, MODE_WRAP, 9, 0, 0, 0, 0, 0, 0));
        for (int e = 1; e <= 5; e++)
            apply($sformatf("rst_post e=%0d", e),
                  mk(0, 1, 0, MODE_WRAP, 9, 0, 0, (e == 5) ? 4'd1 : 4'd0, e == 4, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
